// File: rtl/uart_pkg.sv
// Shared types for the uart echo/traffic controller.
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_ECHO    = 2'd1,
    MODE_PATTERN = 2'd2,
    MODE_COUNT   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_BUSY = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // ECHO needs buffered data; PATTERN and COUNT can always transmit.
  function automatic logic src_avail(input mode_t m, input logic has_data);
    logic avail;
    avail = 1'b0;
    case (m)
      MODE_ECHO:    avail = has_data;
      MODE_PATTERN: avail = 1'b1;
      MODE_COUNT:   avail = 1'b1;
      default:      avail = 1'b0;
    endcase
    return avail;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop happens on the same edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Traffic controller beside the uart core: echoes buffered RX words, or sends a fixed
// pattern or an incrementing count, selected at runtime by mode.
module uart_echo_ctrl
  import uart_pkg::*;
#(
  parameter int                   WORD_SIZE  = 8,
  parameter int                   FIFO_DEPTH = 16,
  parameter logic [WORD_SIZE-1:0] PATTERN    = 8'hAB
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode,
  input  logic                              rx_valid,
  input  logic [WORD_SIZE-1:0]              data_bits_rx,
  input  logic                              tx_ready,
  output logic                              send_valid,
  output logic [WORD_SIZE-1:0]              data_bits_tx,
  output logic [WORD_SIZE-1:0]              led,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  input  logic                              clear_ovf
);

  mode_t                mode_sel;
  state_t               state;
  state_t               state_next;
  logic                 load;
  logic                 pop_en;
  logic                 push_req;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_SIZE-1:0] fifo_rdata;
  logic [WORD_SIZE-1:0] tx_src;
  logic [WORD_SIZE-1:0] cnt_q;
  logic                 send_is_count;
  logic                 ovf_set;

  assign mode_sel = mode_t'(mode);
  assign push_req = rx_valid && (mode_sel == MODE_ECHO);
  assign ovf_set  = push_req && fifo_full && !pop_en;

  uart_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_en),
    .flush (mode_sel != MODE_ECHO),
    .wdata (data_bits_rx),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    tx_src = '0;
    case (mode_sel)
      MODE_ECHO:    tx_src = fifo_rdata;
      MODE_PATTERN: tx_src = PATTERN;
      MODE_COUNT:   tx_src = cnt_q;
      default:      tx_src = '0;
    endcase
  end

  // mode only matters on the IDLE->SEND edge; everything a send needs is latched there.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    pop_en     = 1'b0;
    send_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_ready && src_avail(mode_sel, !fifo_empty)) begin
          state_next = S_SEND;
          load       = 1'b1;
          pop_en     = (mode_sel == MODE_ECHO);
        end
      end
      S_SEND: begin
        send_valid = 1'b1;
        state_next = S_BUSY;
      end
      S_BUSY: begin
        if (!tx_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      data_bits_tx  <= '0;
      send_is_count <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        data_bits_tx  <= tx_src;
        send_is_count <= (mode_sel == MODE_COUNT);
      end
      if (state == S_SEND && send_is_count) begin
        cnt_q <= cnt_q + WORD_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '0;
      overflow <= 1'b0;
    end else begin
      if (rx_valid) begin
        led <= data_bits_rx;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Randomized bench for uart_echo_ctrl with a queue-based reference model and a uart core stand-in.
module tb_uart_echo_ctrl;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = $clog2(D+1);
  localparam logic [W-1:0] PAT = 8'hAB;

  logic          clk;
  logic          rst;
  logic [1:0]    mode;
  logic          rx_valid;
  logic [W-1:0]  data_bits_rx;
  logic          tx_ready;
  logic          send_valid;
  logic [W-1:0]  data_bits_tx;
  logic [W-1:0]  led;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clear_ovf;

  logic          hold;
  int            busy;
  logic          prev_sv;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_fifo[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic         ovf_exp;
  logic [W-1:0] led_exp;

  uart_echo_ctrl #(
    .WORD_SIZE  (W),
    .FIFO_DEPTH (D),
    .PATTERN    (PAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .rx_valid     (rx_valid),
    .data_bits_rx (data_bits_rx),
    .tx_ready     (tx_ready),
    .send_valid   (send_valid),
    .data_bits_tx (data_bits_tx),
    .led          (led),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart core stand-in: goes busy for 20 cycles right after a send_valid pulse
  assign tx_ready = !hold && (busy == 0);

  initial begin
    busy = 0;
    forever begin
      @(negedge clk);
      if (rst) busy = 0;
      else if (send_valid) busy = 20;
      else if (busy > 0) busy--;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_sv) check("sv_pulse_width", {31'd0, send_valid}, 32'd0);
      if (send_valid && !rst) got_q.push_back(data_bits_tx);
      prev_sv = send_valid;
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    @(negedge clk);
    rx_valid     = 1'b1;
    data_bits_rx = w;
    @(negedge clk);
    rx_valid = 1'b0;
    led_exp  = w;
    if (mode == 2'd1) begin
      if (model_fifo.size() < D) model_fifo.push_back(w);
      else ovf_exp = 1'b1;
    end
  endtask

  task automatic wait_sends(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < n * 40 + 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, {31'd0, got_q.size() >= n}, 32'd1);
  endtask

  task automatic settle();
    repeat (30) @(negedge clk);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_word%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_fifo_count"}, {27'd0, fifo_count}, model_fifo.size());
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ovf_exp});
    check({tag, "_led"}, {24'd0, led}, {24'd0, led_exp});
  endtask

  task automatic drain_echo(input string tag);
    int n;
    n = model_fifo.size();
    exp_q = model_fifo;
    got_q.delete();
    @(negedge clk);
    hold = 1'b0;
    wait_sends(n, tag);
    settle();
    model_fifo.delete();
    check({tag, "_drained"}, {27'd0, fifo_count}, 32'd0);
    compare_stream(tag);
  endtask

  initial begin
    logic [W-1:0] w;
    int n;
    int cyc;
    rst = 1'b1; mode = 2'd0; rx_valid = 1'b0; data_bits_rx = '0;
    clear_ovf = 1'b0; hold = 1'b0;
    ovf_exp = 1'b0; led_exp = '0;
    repeat (3) @(negedge clk);
    check("rst_send_valid", {31'd0, send_valid}, 32'd0);
    check("rst_data_tx", {24'd0, data_bits_tx}, 32'd0);
    check_state("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // echo of a fixed three-word message
    mode = 2'd1; hold = 1'b1;
    @(negedge clk);
    push_word(8'h41); push_word(8'h42); push_word(8'h43);
    check_state("echo3");
    drain_echo("echo3");
    check("echo3_led", {24'd0, led}, 32'h43);

    // random echo bursts
    for (int r = 0; r < 4; r++) begin
      hold = 1'b1;
      n = $urandom_range(1, D);
      for (int k = 0; k < n; k++) push_word(W'($urandom));
      check_state($sformatf("echo_rand%0d", r));
      drain_echo($sformatf("echo_rand%0d", r));
    end

    // overflow: 17 words into a 16-deep buffer
    hold = 1'b1;
    for (int k = 0; k < D + 1; k++) push_word(W'($urandom));
    check_state("ovf");
    // set beats clear on the same edge
    w = W'($urandom);
    @(negedge clk);
    rx_valid = 1'b1; data_bits_rx = w; clear_ovf = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clear_ovf = 1'b0; led_exp = w;
    check_state("ovf_set_wins");
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0; ovf_exp = 1'b0;
    check_state("ovf_clear");

    // full FIFO: push on the same edge as the first pop
    got_q.delete();
    exp_q = model_fifo;
    w = W'($urandom);
    @(negedge clk);
    hold = 1'b0; rx_valid = 1'b1; data_bits_rx = w;
    @(negedge clk);
    rx_valid = 1'b0;
    check("pushpop_count", {27'd0, fifo_count}, D);
    check("pushpop_overflow", {31'd0, overflow}, 32'd0);
    check("pushpop_latency", {31'd0, send_valid}, 32'd1);
    check("pushpop_head", {24'd0, data_bits_tx}, {24'd0, exp_q[0]});
    exp_q.push_back(w);
    led_exp = w;
    wait_sends(D + 1, "pushpop");
    settle();
    model_fifo.delete();
    check("pushpop_drained", {27'd0, fifo_count}, 32'd0);
    compare_stream("pushpop");

    // leaving ECHO flushes the buffer
    hold = 1'b1;
    for (int k = 0; k < 5; k++) push_word(W'($urandom));
    check_state("flush_pre");
    @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    model_fifo.delete();
    check("flush_count", {27'd0, fifo_count}, 32'd0);
    got_q.delete();
    hold = 1'b0;
    wait_sends(1, "flush");
    mode = 2'd0;
    settle();
    exp_q.push_back(PAT);
    compare_stream("flush");

    // PATTERN x3, then switch to COUNT while the third send is busy
    mode = 2'd2;
    wait_sends(3, "pat");
    @(negedge clk);
    mode = 2'd3;
    wait_sends(3 + 258, "cnt");
    mode = 2'd0;
    settle();
    for (int k = 0; k < 3; k++) exp_q.push_back(PAT);
    for (int k = 0; k < 258; k++) exp_q.push_back(W'(k % 256));
    compare_stream("pat_cnt");

    // reset in the middle of a send
    mode = 2'd1; hold = 1'b1;
    @(negedge clk);
    for (int k = 0; k < D + 1; k++) push_word(W'($urandom));
    check_state("midrst_pre");
    @(negedge clk);
    hold = 1'b0;
    cyc = 0;
    while (!send_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_sv_seen", {31'd0, send_valid}, 32'd1);
    rst = 1'b1;
    #1;
    model_fifo.delete(); ovf_exp = 1'b0; led_exp = '0;
    check("midrst_send_valid", {31'd0, send_valid}, 32'd0);
    check("midrst_data_tx", {24'd0, data_bits_tx}, 32'd0);
    check_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();

    // count register restarts from zero after reset
    mode = 2'd3;
    wait_sends(2, "cnt_after_rst");
    mode = 2'd0;
    settle();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    compare_stream("cnt_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
